// File: rtl/audio_out_pkg.sv
// Shared register map and field positions for the audio output path.
package audio_out_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_CLEAR  = 2'd3;

  localparam int STS_EMPTY_BIT   = 16;
  localparam int STS_FULL_BIT    = 17;
  localparam int STS_OVF_BIT     = 18;
  localparam int STS_UCNT_LSB    = 20;
  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_THR_LSB    = 8;
  localparam int CLR_OVF_BIT     = 0;
  localparam int CLR_UCNT_BIT    = 1;

  localparam int DEFAULT_DATA_SIZE = 28;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; head_dat is read straight from storage.
// A push into a full FIFO lands only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty    = (level == '0);
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign head_dat = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (do_pop && !do_push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/audio_sample_writer.sv
// CPU-to-stream bridge: Avalon-MM sample writes buffered in a FWFT FIFO, emitted on Avalon-ST.
// Optional underrun counter in STATUS[31:20] is built when AUDIO_UNDERRUN_CNT_EN is defined.
module audio_sample_writer
  import audio_out_pkg::*;
#(
  parameter int DATA_SIZE  = DEFAULT_DATA_SIZE,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 chipselect,
  input  logic [1:0]           address,
  input  logic                 write,
  input  logic [31:0]          writedata,
  input  logic                 read,
  output logic [31:0]          read_data,
  output logic                 source_valid,
  output logic [DATA_SIZE-1:0] source_data,
  input  logic                 source_ready,
  output logic                 irq
);

  logic             push_req;
  logic             pop;
  logic             clear_wr;
  logic             ctrl_wr;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             irq_en;
  logic [LVL_W-1:0] threshold;
  logic [31:0]      rd_mux;
  logic             unused_bits;

  assign push_req     = chipselect & write & (address == ADDR_DATA);
  assign ctrl_wr      = chipselect & write & (address == ADDR_CTRL);
  assign clear_wr     = chipselect & write & (address == ADDR_CLEAR);
  assign source_valid = ~fifo_empty;
  assign pop          = source_valid & source_ready;

  sample_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_dat (writedata[DATA_SIZE-1:0]),
    .pop      (pop),
    .head_dat (source_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

`ifdef AUDIO_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
  logic        ucnt_armed;

  // Counting starts only once software has produced at least one sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt       <= '0;
      ucnt_armed <= 1'b0;
    end else if (clear_wr && writedata[CLR_UCNT_BIT]) begin
      ucnt       <= '0;
      ucnt_armed <= 1'b0;
    end else begin
      if (push_req && (!fifo_full || pop)) ucnt_armed <= 1'b1;
      if (ucnt_armed && source_ready && fifo_empty && ucnt != 16'hFFFF)
        ucnt <= ucnt + 16'd1;
    end
  end

  assign unused_bits = ^{writedata, ucnt[15:12]};
`else
  assign unused_bits = ^writedata;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_STATUS: begin
        rd_mux[LVL_W-1:0]     = level;
        rd_mux[STS_EMPTY_BIT] = fifo_empty;
        rd_mux[STS_FULL_BIT]  = fifo_full;
        rd_mux[STS_OVF_BIT]   = overflow;
`ifdef AUDIO_UNDERRUN_CNT_EN
        rd_mux[STS_UCNT_LSB +: 12] = ucnt[11:0];
`endif
      end
      ADDR_CTRL: begin
        rd_mux[CTRL_IRQ_EN_BIT]          = irq_en;
        rd_mux[CTRL_THR_LSB +: LVL_W]    = threshold;
      end
      default: rd_mux = '0;
    endcase
  end

  // Registers sample pre-update state, so a same-cycle read sees the old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data <= '0;
      overflow  <= 1'b0;
      irq_en    <= 1'b0;
      threshold <= '0;
      irq       <= 1'b0;
    end else begin
      if (chipselect && read) read_data <= rd_mux;
      if (push_req && fifo_full && !pop)
        overflow <= 1'b1;
      else if (clear_wr && writedata[CLR_OVF_BIT])
        overflow <= 1'b0;
      if (ctrl_wr) begin
        irq_en    <= writedata[CTRL_IRQ_EN_BIT];
        threshold <= writedata[CTRL_THR_LSB +: LVL_W];
      end
      irq <= irq_en & (level <= threshold);
    end
  end

endmodule

// File: tb/tb_audio_sample_writer.sv
// Randomized plus directed bench for audio_sample_writer against a queue-based reference model.
module tb_audio_sample_writer;

  localparam int DS    = 28;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0;
  logic [1:0]    addr = '0;
  logic          wr = 1'b0;
  logic [31:0]   wdata = '0;
  logic          rd = 1'b0;
  logic [31:0]   read_data;
  logic          source_valid;
  logic [DS-1:0] source_data;
  logic          ready = 1'b0;
  logic          irq;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state
  int          q[$];
  bit          m_ovf;
  bit          m_irq_en;
  int          m_thr;
  bit          m_irq;
  int          m_cnt;
  bit          m_armed;
  logic [31:0] m_rd;

  always #5 clk = ~clk;

  audio_sample_writer #(
    .DATA_SIZE  (DS),
    .FIFO_DEPTH (DEPTH),
    .LVL_W      (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .chipselect   (cs),
    .address      (addr),
    .write        (wr),
    .writedata    (wdata),
    .read         (rd),
    .read_data    (read_data),
    .source_valid (source_valid),
    .source_data  (source_data),
    .source_ready (ready),
    .irq          (irq)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] v;
    v = 32'(q.size());
    if (q.size() == 0)     v = v | 32'h0001_0000;
    if (q.size() == DEPTH) v = v | 32'h0002_0000;
    if (m_ovf)             v = v | 32'h0004_0000;
`ifdef AUDIO_UNDERRUN_CNT_EN
    v = v | (32'(m_cnt % 4096) << 20);
`endif
    return v;
  endfunction

  function automatic logic [31:0] m_ctrl();
    return 32'(m_irq_en) | (32'(m_thr) << 8);
  endfunction

  // One clock: predict from pre-edge state and inputs, then compare after the edge.
  task automatic step();
    bit          pop_now;
    bit          push_now;
    bit          irq_next;
    int          cnt_next;
    logic [31:0] rd_next;
    pop_now  = (q.size() > 0) && ready;
    push_now = cs && wr && (addr == 2'd0);
    rd_next  = m_rd;
    if (cs && rd) begin
      if (addr == 2'd1)      rd_next = m_status();
      else if (addr == 2'd2) rd_next = m_ctrl();
      else                   rd_next = 32'd0;
    end
    irq_next = m_irq_en && (q.size() <= m_thr);
    cnt_next = m_cnt;
    if (m_armed && ready && q.size() == 0 && m_cnt < 65535) cnt_next = m_cnt + 1;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_ovf = 0; m_irq_en = 0; m_thr = 0; m_irq = 0;
      m_cnt = 0; m_armed = 0; m_rd = '0;
    end else begin
      m_rd  = rd_next;
      m_irq = irq_next;
      m_cnt = cnt_next;
      if (pop_now) void'(q.pop_front());
      if (push_now) begin
        if (q.size() < DEPTH) begin
          q.push_back(int'(wdata & 32'h0FFF_FFFF));
          m_armed = 1;
        end else begin
          m_ovf = 1;
        end
      end
      if (cs && wr && addr == 2'd2) begin
        m_irq_en = wdata[0];
        m_thr    = int'(wdata[8 +: LW]);
      end
      if (cs && wr && addr == 2'd3) begin
        if (wdata[0]) m_ovf = 0;
`ifdef AUDIO_UNDERRUN_CNT_EN
        if (wdata[1]) begin m_cnt = 0; m_armed = 0; end
`endif
      end
    end
    chk_eq("valid", 32'(source_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk_eq("data", 32'(source_data), 32'(q[0]));
    chk_eq("irq", 32'(irq), 32'(m_irq));
    chk_eq("rdata", read_data, m_rd);
  endtask

  task automatic idle_bus();
    cs = 0; wr = 0; rd = 0; addr = '0; wdata = '0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; wdata = d;
    step();
    idle_bus();
  endtask

  task automatic rd_reg(input logic [1:0] a);
    cs = 1; wr = 0; rd = 1; addr = a;
    step();
    idle_bus();
  endtask

  initial begin
    logic [31:0] v;
    m_ovf = 0; m_irq_en = 0; m_thr = 0; m_irq = 0;
    m_cnt = 0; m_armed = 0; m_rd = '0;

    // Post-reset idle
    rst = 1; step(); step(); rst = 0;
    chk_eq("rst_valid", 32'(source_valid), 32'd0);
    chk_eq("rst_irq", 32'(irq), 32'd0);
    rd_reg(2'd1);
    chk_eq("rst_status", read_data, 32'h0001_0000);

    // Single sample held under backpressure
    ready = 0;
    wr_reg(2'd0, 32'h0ABC_DEF0);
    chk_eq("single_valid", 32'(source_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_eq("single_hold", 32'(source_data), 32'h0ABC_DEF0);
    end
    ready = 1; step(); ready = 0;
    chk_eq("single_drop", 32'(source_valid), 32'd0);
    rd_reg(2'd1);
    chk_eq("single_lvl", read_data & 32'h1F, 32'd0);

    // Overflow
    for (int i = 1; i <= 17; i++) wr_reg(2'd0, 32'(i));
    rd_reg(2'd1);
    chk_eq("ovf_status", read_data & 32'h000F_FFFF, 32'h0006_0010);
    ready = 1;
    for (int i = 1; i <= 16; i++) begin
      chk_eq("drain_order", 32'(source_data), 32'(i));
      step();
    end
    ready = 0;
    wr_reg(2'd3, 32'h1);
    rd_reg(2'd1);
    chk_eq("ovf_clear", read_data & 32'h000F_FFFF, 32'h0001_0000);

    // Full plus simultaneous push/pop
    for (int i = 0; i < 16; i++) wr_reg(2'd0, 32'(100 + i));
    ready = 1;
    wr_reg(2'd0, 32'h99);
    ready = 0;
    rd_reg(2'd1);
    chk_eq("full_pp_lvl", read_data & 32'h1F, 32'd16);
    chk_eq("full_pp_ovf", (read_data >> 18) & 32'h1, 32'd0);
    ready = 1;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) chk_eq("full_pp_last", 32'(source_data), 32'h99);
      step();
    end
    ready = 0;

    // IRQ threshold
    wr_reg(2'd2, 32'h0000_0401);
    for (int i = 0; i < 8; i++) wr_reg(2'd0, 32'(200 + i));
    chk_eq("irq_above", 32'(irq), 32'd0);
    ready = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk_eq("irq_rise", 32'(irq), 32'(i >= 5));
    end
    ready = 0;
    wr_reg(2'd2, 32'h0);
    step();
    chk_eq("irq_off", 32'(irq), 32'd0);

    // Reset mid-stream
    wr_reg(2'd2, 32'h0000_0301);
    for (int i = 0; i < 6; i++) wr_reg(2'd0, 32'(300 + i));
    rst = 1; step(); rst = 0;
    chk_eq("mid_rst_valid", 32'(source_valid), 32'd0);
    rd_reg(2'd2);
    chk_eq("mid_rst_ctrl", read_data, 32'd0);
    rd_reg(2'd1);
    chk_eq("mid_rst_status", read_data, 32'h0001_0000);
`ifdef AUDIO_UNDERRUN_CNT_EN
    wr_reg(2'd0, 32'h5);
    ready = 1;
    step();
    for (int i = 0; i < 10; i++) step();
    ready = 0;
    rd_reg(2'd1);
    chk_eq("ucnt_10", read_data >> 20, 32'd10);
    wr_reg(2'd3, 32'h2);
    rd_reg(2'd1);
    chk_eq("ucnt_clr", read_data >> 20, 32'd0);
`endif

    // Randomized traffic with bursty backpressure and rare resets
    for (int c = 0; c < 3000; c++) begin
      int r;
      if (c % 64 == 0) v = 32'($urandom_range(0, 3));
      ready = (v == 0) ? 1'b0 : (v == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      r = int'($urandom_range(0, 99));
      cs = (r < 75);
      wr = ($urandom_range(0, 2) != 0);
      rd = ($urandom_range(0, 2) == 0);
      addr = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      wdata = $urandom;
      if (addr == 2'd2) wdata = {19'd0, 5'($urandom_range(0, 20)), 7'd0, 1'($urandom_range(0, 3) != 0)};
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 0;
    idle_bus();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_writer.md
Name: audio_sample_writer

Overview:
- CPU-to-stream bridge for the audio output path. Software writes samples over an Avalon-MM slave, and the block emits them as an Avalon-ST source toward the audio codec path.
- Buffers samples in an internal FIFO and raises a level-triggered interrupt when the FIFO drains to a programmable threshold, so software can refill it.
- It is the transmit counterpart of driver_interface, which receives a stream and exposes it to the CPU.

Parameters:
- DATA_SIZE, 28, sample width in bits on source_data
- FIFO_DEPTH, 16, FIFO entries; must be a power of two and at least 2
- LVL_W, $clog2(FIFO_DEPTH)+1, width of the fill-level field

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- chipselect  in  1  Avalon-MM select
- address  in  2  register index
- write  in  1  Avalon-MM write strobe
- writedata  in  32  write data
- read  in  1  Avalon-MM read strobe
- read_data  out  32  read data, valid 1 cycle after read
- source_valid  out  1  Avalon-ST valid
- source_data  out  DATA_SIZE  sample at FIFO head
- source_ready  in  1  downstream ready
- irq  out  1  level interrupt

Behaviour:
- Clock and reset (already decided): one clock, clk; reset rst is synchronous and active-high.
- Register map:
  - 0 DATA (write-only; reads return 0)
  - 1 STATUS (read-only): [LVL_W-1:0] fill level, [16] empty, [17] full, [18] overflow sticky
  - 2 CTRL (read/write): [0] irq_en, [LVL_W+7:8] threshold
  - 3 CLEAR (write-only): writing bit0=1 clears overflow; reads return 0
- Reset values:
  - read_data=0, source_valid=0, irq=0
  - FIFO empty, level=0, overflow=0, irq_en=0, threshold=0
  - source_data is don't-care while source_valid=0
- Push: chipselect & write & address==0.
  - Stores writedata[DATA_SIZE-1:0]; upper bits are ignored.
  - Accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the sample is dropped, overflow is set, and the FIFO is unchanged.
- Pop: source_valid & source_ready.
  - source_valid = !empty.
  - The FIFO is first-word-fall-through: source_data is the head entry combinationally from FIFO storage.
  - Write-to-valid latency is 1 cycle: a push on edge N makes source_valid high after edge N.
  - source_data must stay stable while source_valid=1 and source_ready=0.
- Level update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop. Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - When empty, no pop is possible (valid=0); the push lands.
  - When full, both succeed and the level stays FIFO_DEPTH.
- Read: chipselect & read registers read_data on the next edge (latency 1).
  - read_data holds its value when there is no read.
  - Reads have no side effects.
  - A write and a read in the same cycle are both honoured; the read returns pre-write state.
- Writes to CTRL: threshold values above FIFO_DEPTH are stored as written; the comparison still applies.
- irq: registered, irq <= irq_en & (level <= threshold), evaluated on the pre-update level.
  - Clears one cycle after irq_en=0 or after the level rises above threshold.
- Reset mid-operation: the FIFO is flushed, all state returns to reset values, and no partially accepted sample survives.

Optional Feature:
- Macro: AUDIO_UNDERRUN_CNT_EN
- Defined:
  - A 16-bit saturating counter increments each cycle that source_ready=1 and the FIFO is empty, counting only after the first push since reset or since the counter was last cleared.
  - The counter is readable in STATUS[31:20] (low 12 bits of the counter).
  - CLEAR bit1=1 zeroes the counter and re-arms the "first push" condition.
- Undefined: the counter is absent, STATUS[31:20] reads 0, and CLEAR bit1 is ignored.

Decomposition:
- Package audio_out_pkg holds:
  - register address localparams ADDR_DATA/STATUS/CTRL/CLEAR
  - STATUS/CTRL bit-position constants
  - a default DATA_SIZE constant (28)
- Sub-module sample_fifo: synchronous first-word-fall-through FIFO.
  - Parameters: width, depth.
  - Ports: push/pop/full/empty/level.
  - Holds pointer wrap and simultaneous push/pop rules.
- The top level handles register decode, overflow, irq and the optional counter.

Test Plan:
- Post-reset idle: hold rst 2 cycles -> source_valid=0, irq=0, STATUS read returns 0x0001_0000 (empty=1, level=0).
- Single sample: write 0x0ABCDEF0 to DATA with source_ready=0 -> the next cycle shows source_valid=1, source_data=28'hABCDEF0, held stable for 5 cycles; raise source_ready -> one pop, valid drops, level=0.
- Overflow: with source_ready=0, push 17 samples 1..17 (FIFO_DEPTH=16) -> STATUS full=1, overflow=1, level=16; drain shows exactly 1..16 in order; write CLEAR=1 -> overflow=0.
- Full plus simultaneous push/pop: fill to 16, then push 0x99 in the same cycle as a pop -> level stays 16 and 0x99 emerges last.
- IRQ threshold: CTRL irq_en=1, threshold=4; fill 8 then drain one per cycle -> irq rises 1 cycle after level reaches 4; write CTRL irq_en=0 -> irq=0 the next cycle.
- Reset mid-stream: 6 samples queued, assert rst 1 cycle -> level=0, source_valid=0, CTRL reads 0; with AUDIO_UNDERRUN_CNT_EN, push 1 sample, pop it, hold source_ready=1 for 10 cycles -> STATUS[31:20]=10.
